segment_led_scanner: RTL and testbench

Parametrised multiplexed segment-LED display driver and successor to the existing per-strobe segment driver. It generates its own scan timing, inserts ghosting-suppression blanking between digits, and applies global PWM brightness. It supports per-digit enables and independent segment/digit polarity, and uses double-buffered digit data so a frame never tears. It sits between the display-data producer (counter/UI logic) and the board segment/digit pins.

---
 rtl/segment_led_pkg.sv | 18 +
 rtl/segment_led_pwm.sv | 38 +++
 rtl/segment_led_scanner.sv | 181 ++++++++++++++++++
 tb/tb_segment_led_scanner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/segment_led_pkg.sv
// Shared types and helpers for the multiplexed segment-LED scanner.
package segment_led_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } scan_state_t;

    // Widest bus the polarity helper handles; callers slice the result back down.
    localparam int POL_W = 64;

    function automatic logic [POL_W-1:0] apply_polarity(input logic [POL_W-1:0] value,
                                                        input logic             active_low);
        return active_low ? ~value : value;
    endfunction

endpackage

// File: rtl/segment_led_pwm.sv
// Brightness PWM: phase counter over 2^BRIGHTNESS_BITS-1 steps, cleared on each ON entry.
// lit_o reflects the phase the counter takes at the coming edge, so the caller can register it.
module segment_led_pwm #(
    parameter int BRIGHTNESS_BITS = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       run_i,
    input  logic [BRIGHTNESS_BITS-1:0] brightness_i,
    output logic                       lit_o
);

    localparam logic [BRIGHTNESS_BITS-1:0] PWM_LAST = BRIGHTNESS_BITS'((2 ** BRIGHTNESS_BITS) - 2);

    logic [BRIGHTNESS_BITS-1:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = pwm_q;
        if (clear_i) begin
            pwm_d = '0;
        end else if (run_i) begin
            pwm_d = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    // All-ones brightness exceeds every phase value, so it is always lit.
    assign lit_o = (pwm_d < brightness_i);

endmodule

// File: rtl/segment_led_scanner.sv
// Multiplexed segment-LED driver: slot scan with leading blank window, PWM brightness,
// double-buffered digit data (loaded at each frame start) and per-digit enables.
module segment_led_scanner
    import segment_led_pkg::*;
#(
    parameter int   NUMBER_OF_SEGMENTS = 8,
    parameter int   NUMBER_OF_DIGITS   = 4,
    parameter int   SCAN_DIVIDER       = 1000,
    parameter int   BLANK_CYCLES       = 16,
    parameter int   BRIGHTNESS_BITS    = 4,
    parameter logic SEGMENT_ACTIVE_LOW = 1'b0,
    parameter logic DIGIT_ACTIVE_LOW   = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [BRIGHTNESS_BITS-1:0]    brightness,
    input  logic [NUMBER_OF_DIGITS-1:0]   digit_enable,
    input  logic [NUMBER_OF_SEGMENTS-1:0] digits [0:NUMBER_OF_DIGITS-1],
    input  logic                          update,
    output logic [NUMBER_OF_SEGMENTS-1:0] segment_out,
    output logic [NUMBER_OF_DIGITS-1:0]   digit_selector_out,
    output logic                          frame_start
);

    localparam int CNT_W  = $clog2(SCAN_DIVIDER);
    localparam int SLOT_W = $clog2(NUMBER_OF_DIGITS);

    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SCAN_LAST  = CNT_W'(SCAN_DIVIDER - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUMBER_OF_DIGITS - 1);

    localparam logic [NUMBER_OF_SEGMENTS-1:0] SEG_OFF = {NUMBER_OF_SEGMENTS{SEGMENT_ACTIVE_LOW}};
    localparam logic [NUMBER_OF_DIGITS-1:0]   DIG_OFF = {NUMBER_OF_DIGITS{DIGIT_ACTIVE_LOW}};

    scan_state_t                   state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [SLOT_W-1:0]             slot_q, slot_d;
    logic                          load_active;
    logic                          frame_start_d;

    logic [NUMBER_OF_SEGMENTS-1:0] shadow_dig_q [0:NUMBER_OF_DIGITS-1];
    logic [NUMBER_OF_DIGITS-1:0]   shadow_en_q;
    logic [NUMBER_OF_SEGMENTS-1:0] active_dig_q [0:NUMBER_OF_DIGITS-1];
    logic [NUMBER_OF_SEGMENTS-1:0] active_dig_d [0:NUMBER_OF_DIGITS-1];
    logic [NUMBER_OF_DIGITS-1:0]   active_en_q, active_en_d;

    logic                          pwm_clear, pwm_run, pwm_lit;
    logic                          lit_d;
    logic [NUMBER_OF_DIGITS-1:0]   onehot_d;
    logic [NUMBER_OF_SEGMENTS-1:0] seg_raw_d, seg_d, seg_q;
    logic [NUMBER_OF_DIGITS-1:0]   dig_raw_d, dig_d, dig_q;
    logic [POL_W-1:0]              seg_pol, dig_pol;
    logic                          frame_q;

    // Scan sequencing: slot timing is fixed, independent of which digits are enabled.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        slot_d        = slot_q;
        load_active   = 1'b0;
        frame_start_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            slot_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d       = BLANK;
                    cnt_d         = '0;
                    slot_d        = '0;
                    load_active   = 1'b1;
                    frame_start_d = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ON;
                    end
                end
                ON: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        if (slot_q == SLOT_LAST) begin
                            slot_d        = '0;
                            load_active   = 1'b1;
                            frame_start_d = 1'b1;
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The active buffer takes the shadow as it stood before this edge, so an update
    // landing on a frame start is only shown from the following frame.
    always_comb begin
        active_dig_d = active_dig_q;
        active_en_d  = active_en_q;
        if (load_active) begin
            active_dig_d = shadow_dig_q;
            active_en_d  = shadow_en_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            slot_q      <= '0;
            shadow_en_q <= '0;
            active_en_q <= '0;
            for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
                shadow_dig_q[i] <= '0;
                active_dig_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            active_dig_q <= active_dig_d;
            active_en_q  <= active_en_d;
            if (update) begin
                shadow_dig_q <= digits;
                shadow_en_q  <= digit_enable;
            end
        end
    end

    assign pwm_clear = (state_d == ON) && (state_q != ON);
    assign pwm_run   = (state_d == ON);

    segment_led_pwm #(
        .BRIGHTNESS_BITS(BRIGHTNESS_BITS)
    ) u_pwm (
        .clk_i       (clock),
        .rst_i       (reset),
        .clear_i     (pwm_clear),
        .run_i       (pwm_run),
        .brightness_i(brightness),
        .lit_o       (pwm_lit)
    );

    // Outputs are decoded from next-state values so the pins change on the same edge
    // as the scan state; at most one select bit can ever be set.
    always_comb begin
        onehot_d         = '0;
        onehot_d[slot_d] = 1'b1;
        lit_d            = (state_d == ON) && active_en_d[slot_d] && pwm_lit;
        seg_raw_d        = lit_d ? active_dig_d[slot_d] : '0;
        dig_raw_d        = lit_d ? onehot_d : '0;
        seg_pol          = apply_polarity(POL_W'(seg_raw_d), SEGMENT_ACTIVE_LOW);
        dig_pol          = apply_polarity(POL_W'(dig_raw_d), DIGIT_ACTIVE_LOW);
        seg_d            = seg_pol[NUMBER_OF_SEGMENTS-1:0];
        dig_d            = dig_pol[NUMBER_OF_DIGITS-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= frame_start_d;
        end
    end

    assign segment_out        = seg_q;
    assign digit_selector_out = dig_q;
    assign frame_start        = frame_q;

endmodule

// File: tb/tb_segment_led_scanner.sv
// Randomised bench for segment_led_scanner checked every cycle against a frame-time model.
module tb_segment_led_scanner;

    localparam int NS = 8;
    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BB = 2;
    localparam int FRAME = ND * SD;
    localparam int PWM_PERIOD = (2 ** BB) - 1;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [BB-1:0] brightness;
    logic [ND-1:0] digit_enable;
    logic [NS-1:0] digits [0:ND-1];
    logic          update;
    logic [NS-1:0] segment_out;
    logic [ND-1:0] digit_selector_out;
    logic          frame_start;

    int checks;
    int failures;

    segment_led_scanner #(
        .NUMBER_OF_SEGMENTS(NS),
        .NUMBER_OF_DIGITS  (ND),
        .SCAN_DIVIDER      (SD),
        .BLANK_CYCLES      (BC),
        .BRIGHTNESS_BITS   (BB),
        .SEGMENT_ACTIVE_LOW(1'b0),
        .DIGIT_ACTIVE_LOW  (1'b1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .brightness        (brightness),
        .digit_enable      (digit_enable),
        .digits            (digits),
        .update            (update),
        .segment_out       (segment_out),
        .digit_selector_out(digit_selector_out),
        .frame_start       (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t counts clocks since the display (re)started; everything follows from t.
    bit            running;
    int            t;
    logic [NS-1:0] sh_d [0:ND-1];
    logic [NS-1:0] ac_d [0:ND-1];
    logic [ND-1:0] sh_en, ac_en;
    logic [NS-1:0] exp_seg;
    logic [ND-1:0] exp_dig;
    logic          exp_fs;

    always @(posedge clock or posedge reset) begin
        int  slot, pos;
        bit  lit;
        if (reset) begin
            running = 1'b0;
            t       = 0;
            sh_en   = '0;
            ac_en   = '0;
            for (int i = 0; i < ND; i++) begin
                sh_d[i] = '0;
                ac_d[i] = '0;
            end
            exp_seg = '0;
            exp_dig = '1;
            exp_fs  = 1'b0;
        end else begin
            if (!enable) begin
                running = 1'b0;
            end else if (!running) begin
                running = 1'b1;
                t       = 0;
            end else begin
                t = t + 1;
            end
            if (running && (t % FRAME) == 0) begin
                ac_d  = sh_d;
                ac_en = sh_en;
            end
            if (update) begin
                sh_d  = digits;
                sh_en = digit_enable;
            end
            slot = (t / SD) % ND;
            pos  = t % SD;
            lit  = running && (pos >= BC) && ac_en[slot] &&
                   (((pos - BC) % PWM_PERIOD) < int'(brightness));
            exp_seg = lit ? ac_d[slot] : '0;
            exp_dig = lit ? ~(ND'(1) << slot) : '1;
            exp_fs  = running && ((t % FRAME) == 0);
        end
    end

    always @(negedge clock) begin
        chk("segment_out", 32'(segment_out), 32'(exp_seg));
        chk("digit_selector_out", 32'(digit_selector_out), 32'(exp_dig));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
        chk("select_onehot", 32'($countones(~digit_selector_out) <= 1), 32'd1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_update();
        update = 1'b1;
        @(negedge clock);
        update = 1'b0;
    endtask

    task automatic wait_phase(input int target, input string name);
        int k;
        k = 0;
        while (!(running && (t % FRAME) == target) && k < 4 * FRAME) begin
            @(negedge clock);
            k++;
        end
        chk({name, "_reached"}, 32'(running && (t % FRAME) == target), 32'd1);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        enable       = 1'b0;
        brightness   = '0;
        digit_enable = '0;
        update       = 1'b0;
        for (int i = 0; i < ND; i++) digits[i] = '0;
        cycles(3);
        chk("reset_seg", 32'(segment_out), 32'h00);
        chk("reset_dig", 32'(digit_selector_out), 32'hF);
        chk("reset_fs", 32'(frame_start), 32'h0);
        reset = 1'b0;
        cycles(2);

        digits       = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
        digit_enable = 4'hF;
        brightness   = 2'd3;
        pulse_update();
        enable = 1'b1;
        cycles(1);
        chk("first_fs", 32'(frame_start), 32'h1);
        chk("first_blank_dig", 32'(digit_selector_out), 32'hF);
        cycles(10);
        chk("slot1_dig", 32'(digit_selector_out), 32'hD);
        chk("slot1_seg", 32'(segment_out), 32'h06);
        chk("model_slot1_dig", 32'(exp_dig), 32'hD);
        cycles(22);
        chk("second_fs", 32'(frame_start), 32'h1);
        cycles(70);

        brightness = 2'd1;
        cycles(64);
        brightness = 2'd0;
        cycles(64);

        brightness   = 2'd3;
        digit_enable = 4'b1010;
        pulse_update();
        cycles(96);

        digit_enable = 4'hF;
        pulse_update();
        cycles(40);
        wait_phase(17, "slot2");
        digits = '{8'h77, 8'h7C, 8'h39, 8'h5E};
        pulse_update();
        cycles(64);

        wait_phase(12, "slot1");
        enable = 1'b0;
        cycles(1);
        chk("drop_dig", 32'(digit_selector_out), 32'hF);
        chk("drop_seg", 32'(segment_out), 32'h00);
        cycles(3);
        enable = 1'b1;
        cycles(1);
        chk("reenable_fs", 32'(frame_start), 32'h1);
        cycles(2);
        chk("reenable_dig0", 32'(digit_selector_out), 32'hE);
        chk("reenable_seg0", 32'(segment_out), 32'h77);
        cycles(20);

        #2 reset = 1'b1;
        #1;
        chk("async_reset_seg", 32'(segment_out), 32'h00);
        chk("async_reset_dig", 32'(digit_selector_out), 32'hF);
        chk("async_reset_fs", 32'(frame_start), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        cycles(2);

        for (int c = 0; c < 3000; c++) begin
            brightness = BB'($urandom_range(0, (2 ** BB) - 1));
            enable     = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < ND; i++) digits[i] = NS'($urandom);
                digit_enable = ND'($urandom);
                update = 1'b1;
            end else begin
                update = 1'b0;
            end
            if ($urandom_range(0, 7) != 0) brightness = brightness | BB'(1);
            @(negedge clock);
        end
        update = 1'b0;
        cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
